// File: rtl/addsub_pkg.sv
// Shared definitions for the nibble-serial add/subtract controller.
package addsub_pkg;

  localparam int unsigned SLICE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/nibble_addsub.sv
// Combinational 4-bit ripple add/sub slice: s = a + (b ^ {4{sub}}) + cin.
module nibble_addsub
  import addsub_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               sub,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               cout,
  output logic               c_msb
);

  logic [SLICE_W-1:0] bx;
  logic [SLICE_W:0]   c;

  always_comb begin
    bx   = b ^ {SLICE_W{sub}};
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < int'(SLICE_W); i++) begin
      s[i]   = a[i] ^ bx[i] ^ c[i];
      c[i+1] = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
    end
    cout  = c[SLICE_W];
    c_msb = c[SLICE_W-1];
  end

endmodule

// File: rtl/serial_addsub_ctrl.sv
// WIDTH-bit add/subtract computed one nibble per clock on a shared 4-bit slice,
// with valid/ready handshakes on operands and result.
module serial_addsub_ctrl
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned NIBBLES = WIDTH / SLICE_W;
  localparam int unsigned CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               sub_q, sub_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               carry_out_q, carry_out_d;
  logic               overflow_q, overflow_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic [SLICE_W-1:0] slice_s;
  logic               slice_cout;
  logic               slice_c_msb;

  // Operands shift right each RUN cycle so the slice always sees the current nibble at [3:0].
  nibble_addsub u_slice (
    .a     (a_q[SLICE_W-1:0]),
    .b     (b_q[SLICE_W-1:0]),
    .sub   (sub_q),
    .cin   (carry_q),
    .s     (slice_s),
    .cout  (slice_cout),
    .c_msb (slice_c_msb)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    sub_d       = sub_q;
    carry_d     = carry_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d        = op_a;
          b_d        = op_b;
          sub_d      = sub;
          carry_d    = sub;
          cnt_d      = '0;
          state_d    = ST_RUN;
          in_ready_d = 1'b0;
        end
      end

      ST_RUN: begin
        // Sum nibbles enter at the top; after NIBBLES shifts the result is aligned.
        a_d      = a_q >> SLICE_W;
        b_d      = b_q >> SLICE_W;
        result_d = {slice_s, result_q[WIDTH-1:SLICE_W]};
        carry_d  = slice_cout;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(NIBBLES - 1)) begin
          carry_out_d = slice_cout;
          overflow_d  = slice_c_msb ^ slice_cout;
          cnt_d       = '0;
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sub_q       <= 1'b0;
      carry_q     <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sub_q       <= sub_d;
      carry_q     <= carry_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Randomized self-checking bench for serial_addsub_ctrl against an arithmetic reference model.
module tb_serial_addsub_ctrl;

  localparam int unsigned W       = 16;
  localparam int unsigned NIBBLES = W / 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_acc;

  serial_addsub_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: {overflow, carry, result} from plain two's-complement arithmetic.
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic s);
    logic [W:0]   full;
    logic [W-1:0] r;
    logic         v;
    if (s) full = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    else   full = {1'b0, a} + {1'b0, b};
    r = full[W-1:0];
    if (s) v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
    else   v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    return {v, full[W], r};
  endfunction

  // One operation; hold = cycles of out_ready low in DONE while inputs are perturbed.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input int hold, output int acc);
    logic [W+1:0] e;
    int n;
    e = ref_op(a, b, s);
    op_a = a; op_b = b; sub = s; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    chk("in_ready_wait", 32'(n < 50), 32'(1));
    tick();
    acc = cyc;
    in_valid = 1'b0;
    op_a = W'($urandom); op_b = W'($urandom); sub = ~s;
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    chk("latency", 32'(n), 32'(NIBBLES));
    chk("result", 32'(result), 32'(e[W-1:0]));
    chk("carry_out", 32'(carry_out), 32'(e[W]));
    chk("overflow", 32'(overflow), 32'(e[W+1]));
    chk("in_ready_done", 32'(in_ready), 32'(0));
    if (hold > 0) begin
      out_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
        in_valid = 1'b1; op_a = W'($urandom); op_b = W'($urandom);
        tick();
        chk("hold_valid", 32'(out_valid), 32'(1));
        chk("hold_in_ready", 32'(in_ready), 32'(0));
        chk("hold_result", 32'({overflow, carry_out, result}), 32'(e));
      end
    end
    out_ready = 1'b1;
    tick();
    chk("valid_drop", 32'(out_valid), 32'(0));
    chk("back_idle", 32'(in_ready), 32'(1));
    chk("result_held", 32'(result), 32'(e[W-1:0]));
    in_valid = 1'b0;
  endtask

  initial begin
    int acc;
    logic [W-1:0] ra, rb;
    logic rs;
    rst_n = 1'b0; in_valid = 1'b0; op_a = '0; op_b = '0; sub = 1'b0; out_ready = 1'b1;
    tick(); tick();
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_result", 32'({overflow, carry_out, result}), 32'(0));
    rst_n = 1'b1;
    tick();
    chk("idle_stays", 32'(in_ready), 32'(1));

    do_op(16'h1234, 16'h0FCD, 1'b0, 0, acc);
    do_op(16'h0005, 16'h0007, 1'b1, 0, acc);
    do_op(16'h8000, 16'h0001, 1'b1, 0, acc);
    do_op(16'h7FFF, 16'h0001, 1'b0, 0, acc);
    do_op(16'hFFFF, 16'h0001, 1'b0, 0, acc);
    do_op(16'h0000, 16'h0001, 1'b1, 0, acc);
    do_op(16'hA5A5, 16'h5A5B, 1'b0, 3, acc);

    // Abort an operation after two RUN cycles.
    op_a = 16'h1234; op_b = 16'h1111; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_valid", 32'(out_valid), 32'(0));
    chk("abort_result", 32'(result), 32'(0));
    chk("abort_flags", 32'({overflow, carry_out}), 32'(0));
    chk("abort_in_ready", 32'(in_ready), 32'(1));
    for (int i = 0; i < NIBBLES + 2; i++) begin
      tick();
      chk("abort_no_valid", 32'(out_valid), 32'(0));
    end
    do_op(16'h0001, 16'h0001, 1'b0, 0, acc);

    // Streaming with out_ready high; accepts must be NIBBLES+2 apart.
    last_acc = -1;
    for (int k = 0; k < 20; k++) begin
      case ($urandom_range(0, 3))
        0:       ra = 16'hFFFF;
        1:       ra = 16'h8000;
        default: ra = W'($urandom);
      endcase
      rb = W'($urandom);
      rs = 1'($urandom);
      do_op(ra, rb, rs, 0, acc);
      if (last_acc >= 0) chk("accept_spacing", 32'(acc - last_acc), 32'(NIBBLES + 2));
      last_acc = acc;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
